// File: rtl/kws_audio_framer.sv
// Audio sample framer for the KWS accelerator: FIFO buffering, frame markers, overflow flag.
// Optional pre-emphasis filter on the write path, enabled by defining KWS_PREEMPH_EN.
module kws_audio_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [15:0]            in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [15:0]            out_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_start,
  output logic                          frame_end,
  output logic                          overflow,
  input  logic                          ovf_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic signed [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic signed [DATA_W-1:0]   wr_data;

  logic full, empty, push, pop, start_run;

  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign in_ready  = (state_q == S_RUN) && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign start_run = (state_q == S_IDLE) && enable;

`ifdef KWS_PREEMPH_EN
  logic signed [DATA_W-1:0] xprev_q, xprev_d;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // y = x - x_prev + x_prev/32, evaluated with two guard bits before clamping
  function automatic logic signed [DATA_W-1:0] preemph(input logic signed [DATA_W-1:0] x,
                                                       input logic signed [DATA_W-1:0] xp);
    logic signed [17:0] x_w, xp_w, acc;
    x_w  = $signed({{2{x[15]}}, x});
    xp_w = $signed({{2{xp[15]}}, xp});
    acc  = x_w - xp_w + (xp_w >>> 5);
    return sat16(acc);
  endfunction

  assign wr_data = preemph(in_sample, xprev_q);

  always_comb begin
    xprev_d = xprev_q;
    if (start_run)
      xprev_d = '0;
    else if (push)
      xprev_d = in_sample;
  end

  always_ff @(posedge clk) begin
    if (rst)
      xprev_q <= '0;
    else
      xprev_q <= xprev_d;
  end
`else
  assign wr_data = in_sample;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (enable)
          state_d = S_RUN;
        else if (empty)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_run)
      cnt_d = '0;
    else if (pop)
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // A drop in the same cycle as ovf_clear keeps the flag set
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == S_RUN) && in_valid && !in_ready)
      ovf_d = 1'b1;
    else if (ovf_clear)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  // Head is masked while empty so stale storage never reaches the accelerator
  assign out_sample  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_start = pop && (cnt_q == '0);
  assign frame_end   = pop && (cnt_q == CNT_LAST);
  assign overflow    = ovf_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_kws_audio_framer.sv
// Scoreboard bench for kws_audio_framer (FRAME_LEN=4, FIFO_DEPTH=16).
module tb_kws_audio_framer;

  localparam int FIFO_DEPTH = 16;
  localparam int FRAME_LEN  = 4;

  logic                clk;
  logic                rst;
  logic                enable;
  logic signed [15:0]  in_sample;
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  out_sample;
  logic                out_valid;
  logic                out_ready;
  logic                frame_start;
  logic                frame_end;
  logic                overflow;
  logic                ovf_clear;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  typedef struct {
    logic signed [15:0] s;
    logic               fs;
    logic               fe;
  } sb_t;

  sb_t exp_q[$];
  sb_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  kws_audio_framer #(.FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .overflow    (overflow),
    .ovf_clear   (ovf_clear),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v);
    in_valid  = 1'b1;
    in_sample = v;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic expect_out(input logic signed [15:0] v, input logic fs, input logic fe);
    sb_t e;
    e.s = v; e.fs = fs; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!done && fifo_level == 0 && exp_q.size() == 0)
        done = 1'b1;
      if (!done)
        step();
    end
    chk(name, {31'd0, done}, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},    {31'd0, in_ready}, 0);
    chk({tag, "_out_valid"},   {31'd0, out_valid}, 0);
    chk({tag, "_out_sample"},  out_sample, 0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 0);
    chk({tag, "_frame_end"},   {31'd0, frame_end}, 0);
    chk({tag, "_overflow"},    {31'd0, overflow}, 0);
    chk({tag, "_fifo_level"},  {26'd0, fifo_level}, 0);
  endtask

  // Monitor: compare every accepted output beat against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output actual=%0d required=none", out_sample);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_sample",  out_sample, mon_e.s);
        chk("frame_start", {31'd0, frame_start}, {31'd0, mon_e.fs});
        chk("frame_end",   {31'd0, frame_end}, {31'd0, mon_e.fe});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; in_sample = '0; in_valid = 1'b0;
    out_ready = 1'b0; ovf_clear = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Input while idle is ignored and raises no overflow
    send(16'sd55);
    chk("idle_level", {26'd0, fifo_level}, 0);
    chk("idle_overflow", {31'd0, overflow}, 0);
    chk("idle_out_valid", {31'd0, out_valid}, 0);

`ifdef KWS_PREEMPH_EN
    enable = 1'b1; out_ready = 1'b1;
    step();
    expect_out(16'sd1000, 1'b1, 1'b0);
    expect_out(16'sd31, 1'b0, 1'b0);
    expect_out(-16'sd32768, 1'b0, 1'b0);
    send(16'sd1000);
    send(16'sd1000);
    send(-16'sd32768);
    wait_drain("preemph_drain");
`else
    // Basic flow: 1..8, frames of four
    enable = 1'b1; out_ready = 1'b1;
    step();
    chk("run_in_ready", {31'd0, in_ready}, 1);
    for (int i = 1; i <= 8; i++) begin
      expect_out(16'(i), (i == 1 || i == 5), (i == 4 || i == 8));
      send(16'(i));
    end
    wait_drain("basic_drain");

    // Backpressure fill: 20 offered, 16 kept
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 17)
        chk("full_in_ready", {31'd0, in_ready}, 0);
      if (i <= 16)
        expect_out(16'(i), (i % 4 == 1), (i % 4 == 0));
      send(16'(i));
    end
    chk("full_level", {26'd0, fifo_level}, 16);
    chk("full_overflow", {31'd0, overflow}, 1);

    in_valid = 1'b1; in_sample = 16'sd77; ovf_clear = 1'b1;
    step();
    in_valid = 1'b0; ovf_clear = 1'b0;
    chk("ovf_clear_with_drop", {31'd0, overflow}, 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("ovf_clear_alone", {31'd0, overflow}, 0);
    out_ready = 1'b1;
    wait_drain("full_drain");

    // Drain with five queued
    out_ready = 1'b0;
    expect_out(16'sd201, 1'b1, 1'b0);
    expect_out(16'sd202, 1'b0, 1'b0);
    expect_out(16'sd203, 1'b0, 1'b0);
    expect_out(16'sd204, 1'b0, 1'b1);
    expect_out(16'sd205, 1'b1, 1'b0);
    for (int i = 201; i <= 205; i++)
      send(16'(i));
    enable = 1'b0;
    step();
    chk("drain_in_ready", {31'd0, in_ready}, 0);
    chk("drain_level", {26'd0, fifo_level}, 5);
    send(16'sd999);
    chk("drain_ignore_level", {26'd0, fifo_level}, 5);
    chk("drain_ignore_ovf", {31'd0, overflow}, 0);
    out_ready = 1'b1;
    wait_drain("drain_empty");
    step();
    chk("idle_after_drain_in_ready", {31'd0, in_ready}, 0);

    // Re-enable from idle restarts the frame count
    enable = 1'b1;
    step();
    expect_out(16'sd301, 1'b1, 1'b0);
    send(16'sd301);
    wait_drain("restart_drain");

    // Mid-frame reset discards queued samples
    out_ready = 1'b0;
    send(16'sd302);
    send(16'sd303);
    chk("pre_reset_level", {26'd0, fifo_level}, 2);
    rst = 1'b1; out_ready = 1'b1;
    step();
    chk_all_zero("midreset");
    rst = 1'b0;
    step();
    expect_out(16'sd401, 1'b1, 1'b0);
    send(16'sd401);
    wait_drain("post_reset_drain");
`endif

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kws_audio_framer.md
KWS_AUDIO_FRAMER -- requirements
Module: kws_audio_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sample FIFO entries; power of two, at least 4.
REQ-002 Parameter FRAME_LEN, default 256, samples per frame; range 2..65535.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  run request from LA/host.
REQ-006 in_sample  in  16  signed PCM sample from host.
REQ-007 in_valid  in  1  in_sample valid this cycle.
REQ-008 in_ready  out  1  framer can accept a sample.
REQ-009 out_sample  out  16  signed sample to the KWS accelerator (audio_sample).
REQ-010 out_valid  out  1  out_sample valid (sample_valid).
REQ-011 out_ready  in  1  accelerator consumes out_sample.
REQ-012 frame_start  out  1  one-cycle pulse; drives the accelerator start input.
REQ-013 frame_end  out  1  one-cycle pulse on the last sample of a frame.
REQ-014 overflow  out  1  sticky dropped-sample flag.
REQ-015 ovf_clear  in  1  clears overflow.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> IDLE when FIFO empty; DRAIN -> RUN when enable=1.
REQ-019 in_ready = 1 only in RUN with FIFO not full; in_ready = 0 in IDLE and DRAIN.
REQ-020 Push on in_valid && in_ready; pop on out_valid && out_ready.
REQ-021 out_valid = FIFO not empty, in any state; out_sample = FIFO head, held stable while out_valid && !out_ready.
REQ-022 Minimum latency 1 cycle: a sample pushed at edge N is presented with out_valid at N+1; no combinational path in->out.
REQ-023 Simultaneous push and pop: both take effect; fifo_level unchanged.
REQ-024 Full FIFO: push refused even if a pop occurs in the same cycle.
REQ-025 Pointers wrap modulo FIFO_DEPTH; fifo_level range 0..FIFO_DEPTH.
REQ-026 Frame counter 0..FRAME_LEN-1 increments on each pop and wraps to 0 after FRAME_LEN-1.
REQ-027 frame_start = 1 in the pop cycle when the counter is 0.
REQ-028 frame_end = 1 in the pop cycle when the counter is FRAME_LEN-1.
REQ-029 Transition IDLE -> RUN resets the frame counter to 0; DRAIN -> RUN keeps it.
REQ-030 In RUN, in_valid && !in_ready sets overflow; the sample is dropped.
REQ-031 overflow clears on ovf_clear; a set condition in the same cycle wins.
REQ-032 in_valid in IDLE/DRAIN is ignored and does not set overflow.

Reset
REQ-033 On rst: state=IDLE, FIFO empty, pointers 0, frame counter 0, pre-emphasis history 0.
REQ-034 Outputs during and after rst: in_ready=0, out_valid=0, out_sample=0, frame_start=0, frame_end=0, overflow=0, fifo_level=0.
REQ-035 rst mid-frame discards FIFO contents; no frame_end is emitted for the aborted frame.

Configuration
REQ-036 Macro KWS_PREEMPH_EN enables the pre-emphasis filter.
REQ-037 With KWS_PREEMPH_EN: stored value = sat16(x - x_prev + (x_prev >>> 5)), computed in 18-bit signed and saturated to [-32768, 32767].
REQ-038 With KWS_PREEMPH_EN: x_prev updates only on push, and is cleared on IDLE -> RUN.
REQ-039 Without KWS_PREEMPH_EN: samples are stored unmodified; the filter has no logic.
REQ-040 Latency is identical with and without KWS_PREEMPH_EN.

Verification
REQ-041 Basic flow: FRAME_LEN=4, enable=1, push 8 samples 1..8 with out_ready=1 -> output 1..8 in order; frame_start on 1 and 5; frame_end on 4 and 8.
REQ-042 Backpressure fill: out_ready=0, push 20 samples with FIFO_DEPTH=16 -> in_ready=0 after 16 pushes, fifo_level=16, overflow=1, samples 17..20 dropped; then out_ready=1 -> 1..16 out.
REQ-043 Overflow clear and hold: ovf_clear pulsed together with a new drop -> overflow stays 1; ovf_clear alone -> overflow returns to 0.
REQ-044 Drain: enable=0 with 5 samples queued -> in_ready=0; 5 samples are popped, then state is IDLE.
REQ-045 Mid-frame reset: rst asserted mid-frame -> all outputs 0 next cycle; re-enable -> next pop produces frame_start.
REQ-046 Pre-emphasis (KWS_PREEMPH_EN): inputs 1000, 1000, -32768 -> outputs 1000, 31, -32768 (saturated).
